// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: byte FIFO feeding the UART transmit shifter.
// Holds tx_load/tx_data stable until the baud-domain shifter acknowledges
// (synchronized done flag drops), then waits for done to rise again.
// Optional feature macro: UART_TX_IRQ_EN adds tx_irq_o, a one-clk pulse
// when the last queued byte has fully transmitted.
module uart_tx_fifo_ctrl #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       wr_en_i,
  input  logic [7:0]                 wr_data_i,
  input  logic                       clr_err_i,
  input  logic                       tx_done_i,
  output logic                       tx_load_o,
  output logic [7:0]                 tx_data_o,
  output logic                       fifo_full_o,
  output logic                       fifo_empty_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  output logic                       tx_busy_o,
  output logic                       overflow_o,
`ifdef UART_TX_IRQ_EN
  output logic                       tx_irq_o,
`endif
  output logic                       timeout_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, empty_q, busy_q;
  logic                   overflow_q, timeout_q;
  logic                   load_q;
  logic [7:0]             data_q;
  logic [TW-1:0]          timer_q;
  state_e                 state_q, state_d;

  logic done_s, push_s, pop_s, ack_s, tmo_s, finish_s, busy_d;

  assign done_s   = sync_q[SYNC_STAGES-1];
  assign push_s   = wr_en_i && !full_q;
  assign pop_s    = (state_q == ST_IDLE) && !empty_q && done_s;
  assign ack_s    = (state_q == ST_LOAD) && !done_s;
  assign tmo_s    = (state_q == ST_LOAD) && done_s && (timer_q == TMO_LAST);
  assign finish_s = (state_q == ST_WAIT) && done_s;

  // Bring the asynchronous shifter done flag into the clk domain; idle shifter reads as done.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tx_done_i};
    end
  end

  // Next entry count: push and pop in the same cycle cancel.
  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Next FSM state from the handshake events.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = pop_s ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        if (ack_s) begin
          state_d = ST_WAIT;
        end else if (tmo_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WAIT: state_d = finish_s ? ST_IDLE : ST_WAIT;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) || (count_d != CW'(0));
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // FIFO pointers and registered occupancy flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == CW'(0));
    end
  end

  // Load handshake FSM: present a byte, wait for acceptance or timeout, then for done.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b0;
      data_q  <= 8'h00;
      timer_q <= TW'(0);
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            data_q  <= mem_q[rd_ptr_q];
            load_q  <= 1'b1;
            timer_q <= TW'(0);
          end
        end
        ST_LOAD: begin
          timer_q <= timer_q + TW'(1);
          if (ack_s || tmo_s) load_q <= 1'b0;
        end
        default: load_q <= 1'b0;
      endcase
    end
  end

  // Sticky error flags and busy status; a new event wins over clr_err.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (wr_en_i && full_q) overflow_q <= 1'b1;
      else if (clr_err_i)    overflow_q <= 1'b0;
      if (tmo_s)             timeout_q  <= 1'b1;
      else if (clr_err_i)    timeout_q  <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_q;
  // Pulse when the final queued byte finishes and nothing remains to send.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= finish_s && empty_q;
    end
  end
  assign tx_irq_o = irq_q;
`endif

  assign tx_load_o     = load_q;
  assign tx_data_o     = data_q;
  assign fifo_full_o   = full_q;
  assign fifo_empty_o  = empty_q;
  assign fifo_count_o  = count_q;
  assign tx_busy_o     = busy_q;
  assign overflow_o    = overflow_q;
  assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed testbench for uart_tx_fifo_ctrl (DEPTH=8, SYNC_STAGES=2, ACK_TIMEOUT=1024).
module tb_uart_tx_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset, wr_en, clr_err, tx_done;
  logic [7:0] wr_data;
  logic       tx_load, fifo_full, fifo_empty, tx_busy, overflow, timeout_err;
  logic [7:0] tx_data;
  logic [3:0] fifo_count;
  int         checks = 0;
  int         failures = 0;
`ifdef UART_TX_IRQ_EN
  logic       tx_irq;
  int         irq_cnt = 0;
`endif

  uart_tx_fifo_ctrl dut (
    .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .clr_err_i(clr_err), .tx_done_i(tx_done), .tx_load_o(tx_load),
    .tx_data_o(tx_data), .fifo_full_o(fifo_full), .fifo_empty_o(fifo_empty),
    .fifo_count_o(fifo_count), .tx_busy_o(tx_busy), .overflow_o(overflow),
`ifdef UART_TX_IRQ_EN
    .tx_irq_o(tx_irq),
`endif
    .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

`ifdef UART_TX_IRQ_EN
  always @(posedge clk) if (tx_irq === 1'b1) irq_cnt++;
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as the baud-domain shifter: accept one load, then report done.
  task automatic shifter_take(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 64; i++) begin
      if (tx_load === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    if (ok) begin
      b = tx_data;
      tx_done = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
        tick();
        if (tx_load === 1'b0) begin ok = 1'b1; break; end
      end
      tx_done = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0; tx_done = 1'b1;
    tick(); tick();
    checks++; if ({tx_load, fifo_full, fifo_empty, tx_busy, overflow, timeout_err} !== 6'b001000) begin
      failures++; $display("FAIL reset_flags got=%b exp=001000", {tx_load, fifo_full, fifo_empty, tx_busy, overflow, timeout_err});
    end
    checks++; if ({tx_data, fifo_count} !== 12'h000) begin
      failures++; $display("FAIL reset_data_count got=%h/%0d exp=00/0", tx_data, fifo_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_byte();
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    checks++; if (tx_load !== 1'b0 || fifo_count !== 4'd1 || tx_busy !== 1'b1) begin
      failures++; $display("FAIL single_push got load=%b cnt=%0d busy=%b exp 0/1/1", tx_load, fifo_count, tx_busy);
    end
    tick();
    checks++; if (tx_load !== 1'b1 || tx_data !== 8'hA5 || fifo_count !== 4'd0) begin
      failures++; $display("FAIL single_load got load=%b data=%h cnt=%0d exp 1/a5/0", tx_load, tx_data, fifo_count);
    end
    tx_done = 1'b0;
    tick(); tick();
    checks++; if (tx_load !== 1'b1) begin
      failures++; $display("FAIL single_hold got=%b exp=1", tx_load);
    end
    tick();
    checks++; if (tx_load !== 1'b0 || tx_busy !== 1'b1) begin
      failures++; $display("FAIL single_ack got load=%b busy=%b exp 0/1", tx_load, tx_busy);
    end
    tx_done = 1'b1;
    tick(); tick();
    checks++; if (tx_busy !== 1'b1) begin
      failures++; $display("FAIL single_wait got busy=%b exp=1", tx_busy);
    end
    tick();
    checks++; if (tx_busy !== 1'b0) begin
      failures++; $display("FAIL single_idle got busy=%b exp=0", tx_busy);
    end
  endtask

  task automatic test_full_overflow();
    logic [7:0] b;
    bit ok;
    tx_done = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    checks++; if (fifo_full !== 1'b1 || fifo_count !== 4'd8 || overflow !== 1'b0) begin
      failures++; $display("FAIL full got full=%b cnt=%0d ovf=%b exp 1/8/0", fifo_full, fifo_count, overflow);
    end
    wr_en = 1'b1; wr_data = 8'h09;
    tick();
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1 || fifo_count !== 4'd8 || fifo_full !== 1'b1) begin
      failures++; $display("FAIL overflow got ovf=%b cnt=%0d full=%b exp 1/8/1", overflow, fifo_count, fifo_full);
    end
    tx_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      shifter_take(b, ok);
      checks++; if (!ok || b !== 8'(i + 1)) begin
        failures++; $display("FAIL drain_order[%0d] got=%h ok=%b exp=%h", i, b, ok, 8'(i + 1));
      end
    end
    repeat (10) tick();
    checks++; if (tx_load !== 1'b0 || fifo_empty !== 1'b1 || tx_busy !== 1'b0) begin
      failures++; $display("FAIL no_extra_byte got load=%b empty=%b busy=%b exp 0/1/0", tx_load, fifo_empty, tx_busy);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    logic [7:0] b;
    bit ok;
    tx_done = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h31 + i);
      tick();
    end
    wr_en = 1'b0;
    checks++; if (fifo_count !== 4'd3) begin
      failures++; $display("FAIL pp_fill got=%0d exp=3", fifo_count);
    end
    tx_done = 1'b1;
    tick(); tick();
    wr_en = 1'b1; wr_data = 8'h34;
    tick();
    wr_en = 1'b0;
    checks++; if (fifo_count !== 4'd3 || tx_load !== 1'b1 || tx_data !== 8'h31) begin
      failures++; $display("FAIL push_pop got cnt=%0d load=%b data=%h exp 3/1/31", fifo_count, tx_load, tx_data);
    end
    for (int i = 0; i < 4; i++) begin
      shifter_take(b, ok);
      checks++; if (!ok || b !== 8'(8'h31 + i)) begin
        failures++; $display("FAIL pp_order[%0d] got=%h ok=%b exp=%h", i, b, ok, 8'(8'h31 + i));
      end
    end
    repeat (6) tick();
  endtask

  task automatic test_reset_mid_op();
    tx_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h51 + i);
      tick();
    end
    wr_en = 1'b0;
    tx_done = 1'b0;
    tick(); tick(); tick();
    checks++; if (tx_load !== 1'b0 || fifo_count !== 4'd4 || tx_busy !== 1'b1 || overflow !== 1'b1) begin
      failures++; $display("FAIL pre_reset got load=%b cnt=%0d busy=%b ovf=%b exp 0/4/1/1", tx_load, fifo_count, tx_busy, overflow);
    end
    reset = 1'b1; tx_done = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({tx_load, fifo_empty, fifo_full, tx_busy, overflow} !== 5'b01000 || fifo_count !== 4'd0) begin
      failures++; $display("FAIL mid_reset got flags=%b cnt=%0d exp 01000/0", {tx_load, fifo_empty, fifo_full, tx_busy, overflow}, fifo_count);
    end
    repeat (5) tick();
    checks++; if (tx_load !== 1'b0 || tx_busy !== 1'b0) begin
      failures++; $display("FAIL post_reset_quiet got load=%b busy=%b exp 0/0", tx_load, tx_busy);
    end
  endtask

  task automatic test_timeout();
    tx_done = 1'b1;
    wr_en = 1'b1; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    tick();
    checks++; if (tx_load !== 1'b1 || tx_data !== 8'h5A) begin
      failures++; $display("FAIL tmo_load got load=%b data=%h exp 1/5a", tx_load, tx_data);
    end
    repeat (1023) tick();
    checks++; if (tx_load !== 1'b1 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL tmo_edge_minus1 got load=%b err=%b exp 1/0", tx_load, timeout_err);
    end
    tick();
    checks++; if (tx_load !== 1'b0 || timeout_err !== 1'b1 || tx_busy !== 1'b0 || fifo_empty !== 1'b1) begin
      failures++; $display("FAIL tmo_fire got load=%b err=%b busy=%b empty=%b exp 0/1/0/1", tx_load, timeout_err, tx_busy, fifo_empty);
    end
    repeat (5) tick();
    checks++; if (tx_load !== 1'b0) begin
      failures++; $display("FAIL tmo_dropped got load=%b exp=0", tx_load);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin
      failures++; $display("FAIL clr_err got=%b exp=0", timeout_err);
    end
  endtask

`ifdef UART_TX_IRQ_EN
  task automatic test_irq();
    logic [7:0] b;
    bit ok;
    int base;
    base = irq_cnt;
    tx_done = 1'b1;
    wr_en = 1'b1; wr_data = 8'h61; tick();
    wr_data = 8'h62; tick();
    wr_en = 1'b0;
    shifter_take(b, ok);
    checks++; if (!ok || b !== 8'h61) begin
      failures++; $display("FAIL irq_byte1 got=%h ok=%b exp=61", b, ok);
    end
    shifter_take(b, ok);
    checks++; if (!ok || b !== 8'h62 || irq_cnt - base !== 0) begin
      failures++; $display("FAIL irq_byte2 got=%h ok=%b irqs=%0d exp 62/1/0", b, ok, irq_cnt - base);
    end
    repeat (10) tick();
    checks++; if (irq_cnt - base !== 1) begin
      failures++; $display("FAIL irq_count got=%0d exp=1", irq_cnt - base);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_full_overflow();
    test_push_pop_same_cycle();
    test_reset_mid_op();
    test_timeout();
`ifdef UART_TX_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
